fifo_frame_reader: RTL and testbench

Drain-side controller for the byte FIFO: pulls length-prefixed frames out of the FIFO and presents the payload as a valid/ready byte stream with first/last markers. It owns the FIFO read strobe, absorbs the FIFO's one-cycle read latency, and never reads an empty FIFO. It sits between the FIFO and any downstream byte consumer, such as a serializer or packet parser.

---
 rtl/fifo_rd_pkg.sv | 28 ++
 rtl/fifo_frame_reader_if.sv | 36 +++
 rtl/fifo_rd_skid.sv | 92 +++++++++
 rtl/fifo_frame_reader.sv | 139 +++++++++++++
 tb/tb_fifo_frame_reader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the FIFO frame reader: the reader state encoding,
// the default data width, the output buffer depth and a small helper that
// counts how many bytes are already committed to the output buffer.
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

   localparam int DW_DEFAULT = 8;
   localparam int OBUF_DEPTH = 2;
   localparam int LEN_W      = 8;

   typedef enum logic {
      HDR,
      PAYLOAD
   } rd_state_t;

   // Bytes that will occupy the output buffer once everything already in
   // motion settles: what is stored, plus a byte on its way back from the
   // FIFO, minus the byte leaving downstream this cycle. A pop always has
   // occ >= 1, so the subtraction never underflows.
   function automatic logic [2:0] pending_count(input logic [1:0] occ,
                                                input logic       inflight,
                                                input logic       pop);
      return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/fifo_frame_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_frame_reader_if
// Valid/ready byte stream carrying frame payload with first/last markers.
//   valid : byte on data is valid (master -> slave)
//   ready : slave accepts; transfer when valid && ready (slave -> master)
//   data  : payload byte
//   first : data is the first payload byte of its frame
//   last  : data is the last payload byte of its frame
// ---------------------------------------------------------------------------
interface fifo_frame_reader_if #(
   parameter int DW = fifo_rd_pkg::DW_DEFAULT
);

   logic          valid;
   logic          ready;
   logic [DW-1:0] data;
   logic          first;
   logic          last;

   modport master (
      output valid,
      output data,
      output first,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  first,
      input  last,
      output ready
   );

endinterface

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry output buffer, ordered by arrival. Each entry holds a payload
// byte plus its first/last markers; the head entry drives the stream.
//   clk, reset               : clock and synchronous active-high reset
//   push, push_data/first/last : write a new entry at the tail
//   pop                      : drop the head entry
//   head_data/first/last     : contents of the head entry
//   occ                      : number of stored entries, 0..2
// The caller never pushes into a full buffer and never pops an empty one.
// ---------------------------------------------------------------------------
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          push_first,
   input  logic          push_last,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_first,
   output logic          head_last,
   output logic [1:0]    occ
);

   logic [DW-1:0] data0, data1;
   logic          first0, first1;
   logic          last0, last1;
   logic [1:0]    occ_q;

   // Entry 0 is always the head. A push lands in the first free slot; a pop
   // shifts entry 1 forward. On a simultaneous push and pop with one entry
   // stored, the new byte replaces the head directly and occupancy holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         data0  <= '0;
         data1  <= '0;
         first0 <= 1'b0;
         first1 <= 1'b0;
         last0  <= 1'b0;
         last1  <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) begin
                  data0  <= push_data;
                  first0 <= push_first;
                  last0  <= push_last;
               end else begin
                  data1  <= push_data;
                  first1 <= push_first;
                  last1  <= push_last;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               data0  <= data1;
               first0 <= first1;
               last0  <= last1;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  data0  <= push_data;
                  first0 <= push_first;
                  last0  <= push_last;
               end else begin
                  data0  <= data1;
                  first0 <= first1;
                  last0  <= last1;
                  data1  <= push_data;
                  first1 <= push_first;
                  last1  <= push_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head_data  = data0;
   assign head_first = first0;
   assign head_last  = last0;
   assign occ        = occ_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// fifo_frame_reader
// Drains length-prefixed frames (length byte L = 1..255, then L payload
// bytes) from a byte FIFO with one-cycle read latency and presents the
// payload as a valid/ready stream with first/last markers.
//   clk, reset  : clock and synchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_rd     : FIFO read strobe, one cycle per byte
//   fifo_data   : FIFO read data, valid the cycle after fifo_rd
//   m           : payload stream (master side)
//   frame_done  : pulse the cycle after the last byte of a frame transfers
//   hdr_err     : pulse the cycle after a zero-length header arrives
//   busy        : mid-frame, read in flight, or buffered bytes pending
// ---------------------------------------------------------------------------
module fifo_frame_reader
   import fifo_rd_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fifo_empty,
   output logic                fifo_rd,
   input  logic [DW-1:0]       fifo_data,
   fifo_frame_reader_if.master m,
   output logic                frame_done,
   output logic                hdr_err,
   output logic                busy
);

   rd_state_t        state, state_next;
   logic [LEN_W-1:0] remaining, remaining_next;
   logic [LEN_W-1:0] len_loaded, len_next;
   logic             inflight;
   logic             hdr_zero;
   logic [LEN_W-1:0] hdr_len;

   logic             push, push_first, push_last, pop;
   logic [DW-1:0]    head_data;
   logic             head_first, head_last;
   logic [1:0]       occ;
   logic [2:0]       pending;

   assign hdr_len    = fifo_data[LEN_W-1:0];
   assign pop        = m.valid && m.ready;
   assign push       = inflight && (state == PAYLOAD);
   assign push_first = (remaining == len_loaded);
   assign push_last  = (remaining == 8'd1);

   // Read issue: only fetch when the buffer is guaranteed to have room for
   // the byte once it returns. Header reads count as in flight too, which
   // is conservative but keeps the rule uniform. The pop term lets reads
   // resume in the very cycle downstream becomes ready again. Reads are
   // held off during reset so no FIFO byte is lost to a flushed pipeline.
   always_comb begin
      pending = pending_count(occ, inflight, pop);
      fifo_rd = !reset && !fifo_empty && (pending < 3'(OBUF_DEPTH));
   end

   // Next-state logic acts on the byte returning from the FIFO, which is
   // marked by inflight (the strobe of the previous cycle). A zero header
   // is dropped with an error pulse and the reader keeps hunting for a
   // valid header.
   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      len_next       = len_loaded;
      hdr_zero       = 1'b0;
      case (state)
         HDR: begin
            if (inflight) begin
               if (hdr_len == '0) begin
                  hdr_zero = 1'b1;
               end else begin
                  remaining_next = hdr_len;
                  len_next       = hdr_len;
                  state_next     = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (inflight) begin
               remaining_next = remaining - 8'd1;
               if (remaining == 8'd1) begin
                  state_next = HDR;
               end
            end
         end
         default: begin
            state_next = HDR;
         end
      endcase
   end

   // State register plus the in-flight flag and the registered pulses.
   // Clearing inflight on reset is what discards a byte still returning
   // from a read issued just before reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HDR;
         remaining  <= '0;
         len_loaded <= '0;
         inflight   <= 1'b0;
         frame_done <= 1'b0;
         hdr_err    <= 1'b0;
      end else begin
         state      <= state_next;
         remaining  <= remaining_next;
         len_loaded <= len_next;
         inflight   <= fifo_rd;
         frame_done <= pop && head_last;
         hdr_err    <= hdr_zero;
      end
   end

   fifo_rd_skid #(
      .DW(DW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (fifo_data),
      .push_first(push_first),
      .push_last (push_last),
      .pop       (pop),
      .head_data (head_data),
      .head_first(head_first),
      .head_last (head_last),
      .occ       (occ)
   );

   assign m.valid = (occ != 2'd0);
   assign m.data  = head_data;
   assign m.first = head_first;
   assign m.last  = head_last;

   assign busy = (state == PAYLOAD) || inflight || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_frame_reader
// Directed bench for fifo_frame_reader. A small FIFO model with one-cycle
// read latency feeds the reader; a negedge monitor logs every accepted
// byte, every read strobe and the status pulses, and each test compares the
// log against hand-computed frames.
// ---------------------------------------------------------------------------
module tb_fifo_frame_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       fifo_empty;
   logic       fifo_rd;
   logic [7:0] fifo_data = 8'h00;
   logic       frame_done;
   logic       hdr_err;
   logic       busy;

   fifo_frame_reader_if #(.DW(8)) m_if ();

   fifo_frame_reader #(
      .DW(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .fifo_empty(fifo_empty),
      .fifo_rd   (fifo_rd),
      .fifo_data (fifo_data),
      .m         (m_if.master),
      .frame_done(frame_done),
      .hdr_err   (hdr_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         cyc = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model: a strobe at one edge returns the byte for the next cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd && (rd_ptr != wr_ptr)) begin
         fifo_data <= mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   logic [7:0] xfer_data [$];
   logic       xfer_first [$];
   logic       xfer_last [$];
   int         xfer_cyc [$];
   int         rd_cyc [$];
   int         rd_violation = 0;
   int         done_cnt = 0;
   int         hdr_cnt = 0;

   // Monitor, sampled mid-cycle where all signals are settled.
   always @(negedge clk) begin
      if (!reset) begin
         if (m_if.valid && m_if.ready) begin
            xfer_data.push_back(m_if.data);
            xfer_first.push_back(m_if.first);
            xfer_last.push_back(m_if.last);
            xfer_cyc.push_back(cyc);
         end
         if (fifo_rd) rd_cyc.push_back(cyc);
         if (fifo_rd && fifo_empty) rd_violation++;
         if (frame_done) done_cnt++;
         if (hdr_err) hdr_cnt++;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic waitXfers(input string tag, input int target, input int budget);
      int n = 0;
      while (xfer_data.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, xfer_data.size(), target);
   endtask

   task automatic checkRec(input string tag, input int idx, input logic [7:0] d,
                           input logic f, input logic l);
      if (idx >= xfer_data.size()) begin
         checkOutput({tag, "_missing"}, xfer_data.size(), idx + 1);
      end else begin
         checkOutput({tag, "_data"}, xfer_data[idx], d);
         checkOutput({tag, "_first"}, xfer_first[idx], f);
         checkOutput({tag, "_last"}, xfer_last[idx], l);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_fifo_rd"}, fifo_rd, 0);
      checkOutput({tag, "_m_valid"}, m_if.valid, 0);
      checkOutput({tag, "_m_data"}, m_if.data, 0);
      checkOutput({tag, "_m_first"}, m_if.first, 0);
      checkOutput({tag, "_m_last"}, m_if.last, 0);
      checkOutput({tag, "_frame_done"}, frame_done, 0);
      checkOutput({tag, "_hdr_err"}, hdr_err, 0);
      checkOutput({tag, "_busy"}, busy, 0);
   endtask

   int nx, nr, d0, h0;

   initial begin
      reset      = 1'b1;
      m_if.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkIdle("reset");

      // Single frame 03 A1 A2 A3
      @(posedge clk);
      #1;
      m_if.ready = 1'b1;
      nx = xfer_data.size(); nr = rd_cyc.size(); d0 = done_cnt;
      applyStimulus(8'h03); applyStimulus(8'hA1);
      applyStimulus(8'hA2); applyStimulus(8'hA3);
      waitXfers("single_count", nx + 3, 40);
      repeat (3) @(negedge clk);
      checkRec("single_b0", nx, 8'hA1, 1'b1, 1'b0);
      checkRec("single_b1", nx + 1, 8'hA2, 1'b0, 1'b0);
      checkRec("single_b2", nx + 2, 8'hA3, 1'b0, 1'b1);
      if (xfer_cyc.size() >= nx + 3 && rd_cyc.size() > nr) begin
         checkOutput("single_latency", xfer_cyc[nx] - rd_cyc[nr], 3);
         checkOutput("single_back2back", xfer_cyc[nx + 2] - xfer_cyc[nx], 2);
      end else begin
         checkOutput("single_timing_log", rd_cyc.size(), nr + 1);
      end
      checkOutput("single_frame_done", done_cnt - d0, 1);
      checkOutput("single_busy_end", busy, 0);

      // Back-to-back frames 01 55 02 66 77
      @(posedge clk);
      #1;
      nx = xfer_data.size(); d0 = done_cnt;
      applyStimulus(8'h01); applyStimulus(8'h55);
      applyStimulus(8'h02); applyStimulus(8'h66); applyStimulus(8'h77);
      waitXfers("b2b_count", nx + 3, 40);
      repeat (3) @(negedge clk);
      checkRec("b2b_55", nx, 8'h55, 1'b1, 1'b1);
      checkRec("b2b_66", nx + 1, 8'h66, 1'b1, 1'b0);
      checkRec("b2b_77", nx + 2, 8'h77, 1'b0, 1'b1);
      checkOutput("b2b_frame_done", done_cnt - d0, 2);
      checkOutput("b2b_rd_when_empty", rd_violation, 0);

      // Backpressure 04 10 11 12 13 with ready low for 10 cycles
      @(posedge clk);
      #1;
      m_if.ready = 1'b0;
      nx = xfer_data.size(); nr = rd_cyc.size();
      applyStimulus(8'h04); applyStimulus(8'h10); applyStimulus(8'h11);
      applyStimulus(8'h12); applyStimulus(8'h13);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("bp_m_valid", m_if.valid, 1);
      checkOutput("bp_m_data", m_if.data, 8'h10);
      checkOutput("bp_m_first", m_if.first, 1);
      checkOutput("bp_fifo_rd", fifo_rd, 0);
      checkOutput("bp_reads", rd_cyc.size() - nr, 3);
      checkOutput("bp_no_xfer", xfer_data.size() - nx, 0);
      checkOutput("bp_busy", busy, 1);
      @(posedge clk);
      #1;
      m_if.ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_rd_resume", fifo_rd, 1);
      waitXfers("bp_count", nx + 4, 40);
      checkRec("bp_10", nx, 8'h10, 1'b1, 1'b0);
      checkRec("bp_11", nx + 1, 8'h11, 1'b0, 1'b0);
      checkRec("bp_12", nx + 2, 8'h12, 1'b0, 1'b0);
      checkRec("bp_13", nx + 3, 8'h13, 1'b0, 1'b1);

      // Zero header 00 02 B0 B1
      @(posedge clk);
      #1;
      nx = xfer_data.size(); h0 = hdr_cnt;
      applyStimulus(8'h00); applyStimulus(8'h02);
      applyStimulus(8'hB0); applyStimulus(8'hB1);
      waitXfers("zh_count", nx + 2, 40);
      repeat (3) @(negedge clk);
      checkOutput("zh_hdr_err", hdr_cnt - h0, 1);
      checkRec("zh_B0", nx, 8'hB0, 1'b1, 1'b0);
      checkRec("zh_B1", nx + 1, 8'hB1, 1'b0, 1'b1);

      // Starvation: 03 then C0 C1 C2 one every 5 cycles
      @(posedge clk);
      #1;
      nx = xfer_data.size(); nr = rd_cyc.size();
      applyStimulus(8'h03);
      for (int i = 0; i < 3; i++) begin
         repeat (5) @(posedge clk);
         #1 applyStimulus(8'hC0 + 8'(i));
      end
      waitXfers("starve_count", nx + 3, 40);
      checkRec("starve_C0", nx, 8'hC0, 1'b1, 1'b0);
      checkRec("starve_C1", nx + 1, 8'hC1, 1'b0, 1'b0);
      checkRec("starve_C2", nx + 2, 8'hC2, 1'b0, 1'b1);
      checkOutput("starve_reads", rd_cyc.size() - nr, 4);
      checkOutput("starve_rd_when_empty", rd_violation, 0);

      // Reset mid-frame: 05 D0 D1, then D2 in flight when reset hits
      @(posedge clk);
      #1;
      nx = xfer_data.size(); h0 = hdr_cnt;
      applyStimulus(8'h05); applyStimulus(8'hD0); applyStimulus(8'hD1);
      waitXfers("rst_pre_count", nx + 2, 40);
      @(posedge clk);
      #1 applyStimulus(8'hD2);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkIdle("rst_mid");
      @(posedge clk);
      #1;
      applyStimulus(8'h01); applyStimulus(8'hEE);
      waitXfers("rst_post_count", nx + 3, 40);
      repeat (3) @(negedge clk);
      checkRec("rst_EE", nx + 2, 8'hEE, 1'b1, 1'b1);
      checkOutput("rst_no_hdr_err", hdr_cnt - h0, 0);
      checkOutput("final_rd_when_empty", rd_violation, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
